// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: datapath widths, fetch FSM states and the
// default ROM start address.
package hack_pkg;

   localparam int ADDR_W = 15;
   localparam int WORD_W = 16;

   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 15'h0000;

   typedef enum logic {
      WAIT_ROM = 1'b0,
      RUN      = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/hack_fetch_skid.sv
// Two-entry FIFO of {pc, instr} that catches ROM read data while the fetch
// output register is stalled. Push and pop may happen in the same cycle.
module hack_fetch_skid
   import hack_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic [WORD_W-1:0] push_instr,
   input  logic              pop,
   input  logic              flush,
   output logic [1:0]        count,
   output logic [ADDR_W-1:0] head_pc,
   output logic [WORD_W-1:0] head_instr
);

   logic [ADDR_W-1:0] entry_pc_q [2];
   logic [ADDR_W-1:0] entry_pc_d [2];
   logic [WORD_W-1:0] entry_instr_q [2];
   logic [WORD_W-1:0] entry_instr_d [2];
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [1:0]        count_q, count_d;

   // Next-state for pointers, occupancy and storage.
   always_comb begin
      entry_pc_d    = entry_pc_q;
      entry_instr_d = entry_instr_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            entry_pc_d[wr_ptr_q]    = push_pc;
            entry_instr_d[wr_ptr_q] = push_instr;
            wr_ptr_d                = ~wr_ptr_q;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         entry_pc_q[0]    <= 15'h0000;
         entry_pc_q[1]    <= 15'h0000;
         entry_instr_q[0] <= 16'h0000;
         entry_instr_q[1] <= 16'h0000;
         rd_ptr_q         <= 1'b0;
         wr_ptr_q         <= 1'b0;
         count_q          <= 2'd0;
      end else begin
         entry_pc_q    <= entry_pc_d;
         entry_instr_q <= entry_instr_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   assign count      = count_q;
   assign head_pc    = entry_pc_q[rd_ptr_q];
   assign head_instr = entry_instr_q[rd_ptr_q];

endmodule

// File: rtl/hack_fetch.sv
// Hack CPU instruction fetch: waits for the ROM loader, then streams
// instructions to execute over valid/ack, hiding the 1-cycle SPRAM latency.
// Optional feature macro HACK_FETCH_SKID_EN: stalled read data is parked in
// a 2-entry skid buffer instead of re-reading the ROM, which removes the
// instr_ack -> rom_raddr combinational path.
module hack_fetch
   import hack_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rom_ready,
   output logic [ADDR_W-1:0] rom_raddr,
   input  logic [WORD_W-1:0] rom_rdata,
   output logic [WORD_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ack,
   input  logic              jump_valid,
   input  logic [ADDR_W-1:0] jump_target
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic              out_valid_q, out_valid_d;
   logic [WORD_W-1:0] out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] out_pc_q, out_pc_d;
   logic [ADDR_W-1:0] rom_raddr_s;
   logic              accept;
   logic              out_free;

`ifdef HACK_FETCH_SKID_EN
   logic              skid_push, skid_pop, skid_flush, issue_ok;
   logic [1:0]        skid_count;
   logic [ADDR_W-1:0] skid_head_pc;
   logic [WORD_W-1:0] skid_head_instr;

   hack_fetch_skid u_skid (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (skid_push),
      .push_pc    (inflight_pc_q),
      .push_instr (rom_rdata),
      .pop        (skid_pop),
      .flush      (skid_flush),
      .count      (skid_count),
      .head_pc    (skid_head_pc),
      .head_instr (skid_head_instr)
   );
`else
   logic              stall;
`endif

   // FSM next state, issue/capture/replay datapath and ROM address.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inflight_d    = inflight_q;
      inflight_pc_d = inflight_pc_q;
      out_valid_d   = out_valid_q;
      out_instr_d   = out_instr_q;
      out_pc_d      = out_pc_q;
      rom_raddr_s   = 15'h0000;
      accept        = out_valid_q & instr_ack;
      out_free      = ~out_valid_q | accept;
`ifdef HACK_FETCH_SKID_EN
      skid_push  = 1'b0;
      skid_pop   = 1'b0;
      skid_flush = 1'b0;
      // Leave room for whatever is already in flight.
      issue_ok   = (skid_count == 2'd0) | ((skid_count == 2'd1) & ~inflight_q);
`else
      stall      = inflight_q & ~out_free;
`endif
      case (state_q)
         WAIT_ROM: begin
            if (rom_ready) begin
               state_d = RUN;
            end else begin
               state_d = WAIT_ROM;
            end
         end
         RUN: begin
`ifdef HACK_FETCH_SKID_EN
            rom_raddr_s = pc_q;
`else
            rom_raddr_s = stall ? inflight_pc_q : pc_q;
`endif
            if (!rom_ready) begin
               // ROM is being reloaded: drop everything and restart later.
               state_d       = WAIT_ROM;
               pc_d          = RESET_PC;
               inflight_d    = 1'b0;
               inflight_pc_d = 15'h0000;
               out_valid_d   = 1'b0;
               out_instr_d   = 16'h0000;
               out_pc_d      = 15'h0000;
`ifdef HACK_FETCH_SKID_EN
               skid_flush    = 1'b1;
`endif
            end else if (jump_valid) begin
               // Redirect wins over everything; this cycle's read is discarded.
               out_valid_d = 1'b0;
               inflight_d  = 1'b0;
               pc_d        = jump_target;
`ifdef HACK_FETCH_SKID_EN
               skid_flush  = 1'b1;
`endif
            end else begin
`ifdef HACK_FETCH_SKID_EN
               if (out_free) begin
                  if (skid_count != 2'd0) begin
                     // Oldest data lives in the buffer; new data queues behind.
                     out_valid_d = 1'b1;
                     out_instr_d = skid_head_instr;
                     out_pc_d    = skid_head_pc;
                     skid_pop    = 1'b1;
                     skid_push   = inflight_q;
                  end else if (inflight_q) begin
                     out_valid_d = 1'b1;
                     out_instr_d = rom_rdata;
                     out_pc_d    = inflight_pc_q;
                  end else if (accept) begin
                     out_valid_d = 1'b0;
                  end else begin
                     out_valid_d = out_valid_q;
                  end
               end else begin
                  skid_push = inflight_q;
               end
               if (issue_ok) begin
                  inflight_d    = 1'b1;
                  inflight_pc_d = pc_q;
                  pc_d          = pc_q + 15'd1;
               end else begin
                  inflight_d    = 1'b0;
               end
`else
               if (stall) begin
                  // Output busy: re-read the same word next cycle.
                  inflight_d = 1'b1;
                  pc_d       = pc_q;
               end else begin
                  if (inflight_q) begin
                     out_valid_d = 1'b1;
                     out_instr_d = rom_rdata;
                     out_pc_d    = inflight_pc_q;
                  end else if (accept) begin
                     out_valid_d = 1'b0;
                  end else begin
                     out_valid_d = out_valid_q;
                  end
                  inflight_d    = 1'b1;
                  inflight_pc_d = pc_q;
                  pc_d          = pc_q + 15'd1;
               end
`endif
            end
         end
         default: begin
            state_d = WAIT_ROM;
         end
      endcase
   end

   // State, program counter, in-flight tracking and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= WAIT_ROM;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 15'h0000;
         out_valid_q   <= 1'b0;
         out_instr_q   <= 16'h0000;
         out_pc_q      <= 15'h0000;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         out_valid_q   <= out_valid_d;
         out_instr_q   <= out_instr_d;
         out_pc_q      <= out_pc_d;
      end
   end

   assign rom_raddr   = rom_raddr_s;
   assign instr       = out_instr_q;
   assign instr_pc    = out_pc_q;
   assign instr_valid = out_valid_q;

endmodule

// File: tb/tb_hack_fetch.sv
// Directed self-checking bench for hack_fetch with a behavioural 1-cycle ROM
// and a scoreboard of expected instruction addresses.
module tb_hack_fetch;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        rom_ready;
   logic [14:0] rom_raddr;
   logic [15:0] rom_rdata;
   logic [15:0] instr;
   logic [14:0] instr_pc;
   logic        instr_valid;
   logic        instr_ack;
   logic        jump_valid;
   logic [14:0] jump_target;

   int          cmp_n  = 0;
   int          fail_n = 0;
   logic [14:0] exp_q [$];

   always #5 clk = ~clk;

   hack_fetch #(.RESET_PC(15'h0000)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rom_ready   (rom_ready),
      .rom_raddr   (rom_raddr),
      .rom_rdata   (rom_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ack   (instr_ack),
      .jump_valid  (jump_valid),
      .jump_target (jump_target)
   );

   // ROM contents: word at address a is a+1 (so ROM[0..3] = 0001..0004).
   function automatic logic [15:0] rom_word(input logic [14:0] a);
      return {1'b0, a} + 16'd1;
   endfunction

   // Synchronous-read ROM model.
   always @(posedge clk) rom_rdata <= rom_word(rom_raddr);

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_n++;
      assert (obs === exp) else begin
         fail_n++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs after the falling edge, check valid and any
   // consumed instruction against the scoreboard.
   task automatic tick(input logic ack, input logic jv, input logic [14:0] jt,
                       input logic rdy, input logic expv);
      logic [14:0] e;
      @(negedge clk);
      instr_ack   = ack;
      jump_valid  = jv;
      jump_target = jt;
      rom_ready   = rdy;
      #1;
      check("instr_valid", 32'(instr_valid), 32'(expv));
      if ((instr_valid === 1'b1) && ack) begin
         cmp_n++;
         assert (exp_q.size() > 0) else begin
            fail_n++;
            $error("FAIL sb_empty: observed pc %h expected no output", instr_pc);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("instr_pc", 32'(instr_pc), 32'(e));
            check("instr", 32'(instr), 32'(rom_word(e)));
         end
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      rom_ready   = 1'b0;
      instr_ack   = 1'b0;
      jump_valid  = 1'b0;
      jump_target = 15'h0000;
      repeat (2) @(negedge clk);
      #1;
      check("rst_instr", 32'(instr), 32'd0);
      check("rst_instr_pc", 32'(instr_pc), 32'd0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_rom_raddr", 32'(rom_raddr), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Startup: ROM busy for 10 cycles, then stream.
      for (int i = 0; i < 12; i++) exp_q.push_back(15'(i));
      repeat (10) tick(1'b1, 1'b0, 15'h0000, 1'b0, 1'b0);
      check("wait_raddr", 32'(rom_raddr), 32'd0);
      tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b0);                // cycle R
      tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b0);                // R+1
      check("issue_reset_pc", 32'(rom_raddr), 32'd0);
      tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b0);                // R+2
      check("issue_pc1", 32'(rom_raddr), 32'd1);
      repeat (5) tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b1);     // pc 0..4

      // Backpressure on pc 5.
      repeat (5) begin
         tick(1'b0, 1'b0, 15'h0000, 1'b1, 1'b1);
         check("bp_pc", 32'(instr_pc), 32'd5);
         check("bp_instr", 32'(instr), 32'(rom_word(15'd5)));
      end
      repeat (7) tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b1);     // pc 5..11

      // ROM reload mid-stream.
      tick(1'b0, 1'b0, 15'h0000, 1'b0, 1'b1);
      exp_q.delete();
      repeat (3) begin
         tick(1'b0, 1'b0, 15'h0000, 1'b0, 1'b0);
         check("reload_raddr", 32'(rom_raddr), 32'd0);
      end
      for (int i = 0; i < 3; i++) exp_q.push_back(15'(i));
      tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b0);
      check("reload_issue_pc", 32'(rom_raddr), 32'd0);
      tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b1);                // pc 0
      tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b1);                // pc 1

      // Jump with ack of pc 2 in the same cycle.
      tick(1'b1, 1'b1, 15'h0100, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) exp_q.push_back(15'h0100 + 15'(i));
      tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b0);
      check("jump_issue", 32'(rom_raddr), 32'h100);
      tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b0);
      repeat (3) tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b1);     // 100..102

      // Jump near the top of the address space to exercise wrap.
      tick(1'b1, 1'b1, 15'h7FFE, 1'b1, 1'b1);                // 103 + jump
      exp_q.push_back(15'h7FFE);
      exp_q.push_back(15'h7FFF);
      exp_q.push_back(15'h0000);
      exp_q.push_back(15'h0001);
      repeat (2) tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b0);
      repeat (4) tick(1'b1, 1'b0, 15'h0000, 1'b1, 1'b1);
      check("sb_left", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset in the middle of a cycle.
      tick(1'b0, 1'b0, 15'h0000, 1'b1, 1'b1);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_instr", 32'(instr), 32'd0);
      check("async_instr_pc", 32'(instr_pc), 32'd0);
      check("async_instr_valid", 32'(instr_valid), 32'd0);
      check("async_rom_raddr", 32'(rom_raddr), 32'd0);
      rom_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      tick(1'b0, 1'b0, 15'h0000, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end

endmodule
